// File: rtl/clk_freq_meter_pkg.sv
// Shared definitions for the clock frequency meter: FSM encoding and the default gate length.
package clk_freq_meter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGate = 2'd1,
        StDone = 2'd2
    } meter_state_e;

    // 1 s window at a 100 MHz system clock, so the count reads directly in Hz
    localparam int unsigned GATE_CYCLES_DFLT = 100000000;
    localparam int unsigned CNT_W_DFLT       = 32;

endpackage

// File: rtl/clk_freq_meter_if.sv
// Request/result bundle of the frequency meter; master is the requester, slave is the meter.
interface clk_freq_meter_if #(
    parameter int unsigned CNT_W = 32
);
    logic             start;
    logic             cont;
    logic [CNT_W-1:0] freq;
    logic             freq_valid;
    logic             busy;
    logic             overflow;

    modport master (
        output start, cont,
        input  freq, freq_valid, busy, overflow
    );

    modport slave (
        input  start, cont,
        output freq, freq_valid, busy, overflow
    );
endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with a delay flop; emits a one-cycle pulse on each synchronized rise.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);
    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/clk_freq_meter.sv
// Counts rising edges of an asynchronous input over a fixed window of system clock cycles.
module clk_freq_meter
    import clk_freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = GATE_CYCLES_DFLT,
    parameter int unsigned CNT_W       = CNT_W_DFLT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in_i,
    clk_freq_meter_if.slave  meas_if
);
    localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]    GateLoad = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntMax   = '1;

    meter_state_e     state_q, state_d;
    logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] freq_q, freq_d;
    logic             ovf_q, ovf_d;
    logic             edge_pulse;
    logic             load;

    sync_edge_det u_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (sig_in_i),
        .rise_o (edge_pulse)
    );

    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        freq_d     = freq_q;
        ovf_d      = ovf_q;
        load       = 1'b0;

        unique case (state_q)
            StIdle: load = meas_if.start | meas_if.cont;
            StGate: begin
                gate_cnt_d = gate_cnt_q - 1'b1;
                if (edge_pulse && (edge_cnt_q != CntMax)) begin
                    edge_cnt_d = edge_cnt_q + 1'b1;
                    if (edge_cnt_d == CntMax) sat_d = 1'b1;
                end
                // Capture on the last gate cycle so freq is already valid during DONE
                if (gate_cnt_q == '0) begin
                    state_d = StDone;
                    freq_d  = edge_cnt_d;
                    ovf_d   = sat_d;
                end
            end
            StDone: begin
                state_d = StIdle;
                load    = meas_if.cont;
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            state_d    = StGate;
            gate_cnt_d = GateLoad;
            edge_cnt_d = '0;
            sat_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            freq_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            freq_q     <= freq_d;
            ovf_q      <= ovf_d;
        end
    end

    assign meas_if.freq       = freq_q;
    assign meas_if.overflow   = ovf_q;
    assign meas_if.freq_valid = (state_q == StDone);
    assign meas_if.busy       = (state_q == StGate);

endmodule

// File: tb/tb_clk_freq_meter.sv
// Randomized-phase bench for clk_freq_meter: edge counts come from a recorded-rise reference model.
module tb_clk_freq_meter;
    localparam int G = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sig_in = 1'b0;
    int   checks = 0;
    int   errors = 0;

    clk_freq_meter_if #(.CNT_W(32)) a_if ();
    clk_freq_meter_if #(.CNT_W(8))  b_if ();

    clk_freq_meter #(.GATE_CYCLES(G), .CNT_W(32)) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .sig_in_i (sig_in),
        .meas_if  (a_if.slave)
    );

    clk_freq_meter #(.GATE_CYCLES(G), .CNT_W(8)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .sig_in_i (sig_in),
        .meas_if  (b_if.slave)
    );

    always #500 clk = ~clk;

    // Reference record: index of every clock edge that first samples sig_in high
    int   cyc = 0;
    logic sig_prev = 1'b0;
    int   rises[$];
    always @(posedge clk) begin
        if (sig_in && !sig_prev) rises.push_back(cyc);
        sig_prev <= sig_in;
        cyc      <= cyc + 1;
    end

    bit gen_on = 1'b0;
    int gen_half = 5000;
    always begin
        wait (gen_on);
        #(gen_half);
        if (gen_on) sig_in = ~sig_in;
    end

    // A rise sampled at edge k is counted at edge k+2; the window counts at edges t+1..t+G
    function automatic int model_count(input int t);
        int n = 0;
        foreach (rises[i]) if (rises[i] >= t - 1 && rises[i] <= t + G - 2) n++;
        return n;
    endfunction

    task automatic start_gen(input int half);
        int offset;
        @(negedge clk);
        offset = $urandom_range(1, 499);
        if (offset % 50 == 0) offset++;
        #(offset);
        sig_in   = 1'b0;
        gen_half = half;
        gen_on   = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    task automatic stop_gen();
        gen_on = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic run_window(input bit inst_b, input int rise_rel, output int t, output int v);
        @(negedge clk);
        if (inst_b) b_if.start = 1'b1; else a_if.start = 1'b1;
        @(negedge clk);
        b_if.start = 1'b0;
        a_if.start = 1'b0;
        t = cyc - 1;
        v = -1;
        for (int i = 0; i < G + 20 && v < 0; i++) begin
            @(negedge clk);
            if (rise_rel >= 0 && cyc == t + rise_rel) sig_in = 1'b1;
            if (inst_b ? b_if.freq_valid : a_if.freq_valid) v = cyc - 1;
        end
    endtask

    task automatic wait_valid_a(output int v);
        v = -1;
        for (int i = 0; i < G + 20 && v < 0; i++) begin
            @(negedge clk);
            if (a_if.freq_valid) v = cyc - 1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks += 8;
        if (a_if.freq !== 32'd0) begin errors++; $display("FAIL reset_a_freq got %0d want 0", a_if.freq); end
        if (a_if.freq_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid got %b want 0", a_if.freq_valid); end
        if (a_if.busy !== 1'b0) begin errors++; $display("FAIL reset_a_busy got %b want 0", a_if.busy); end
        if (a_if.overflow !== 1'b0) begin errors++; $display("FAIL reset_a_ovf got %b want 0", a_if.overflow); end
        if (b_if.freq !== 8'd0) begin errors++; $display("FAIL reset_b_freq got %0d want 0", b_if.freq); end
        if (b_if.freq_valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid got %b want 0", b_if.freq_valid); end
        if (b_if.busy !== 1'b0) begin errors++; $display("FAIL reset_b_busy got %b want 0", b_if.busy); end
        if (b_if.overflow !== 1'b0) begin errors++; $display("FAIL reset_b_ovf got %b want 0", b_if.overflow); end
        rst = 1'b0;
    endtask

    task automatic test_period10();
        int t, v, exp;
        start_gen(5000);
        run_window(1'b0, -1, t, v);
        exp = model_count(t);
        checks += 5;
        if (v !== t + G) begin errors++; $display("FAIL p10_latency got %0d want %0d", v, t + G); end
        if (a_if.freq !== 32'(exp)) begin errors++; $display("FAIL p10_model got %0d want %0d", a_if.freq, exp); end
        if (a_if.freq !== 32'd100) begin errors++; $display("FAIL p10_freq got %0d want 100", a_if.freq); end
        if (a_if.overflow !== 1'b0) begin errors++; $display("FAIL p10_ovf got %b want 0", a_if.overflow); end
        @(negedge clk);
        if (a_if.freq_valid !== 1'b0 || a_if.freq !== 32'(exp)) begin
            errors++;
            $display("FAIL p10_hold got valid=%b freq=%0d want valid=0 freq=%0d",
                     a_if.freq_valid, a_if.freq, exp);
        end
    endtask

    task automatic test_static();
        int t, v;
        stop_gen();
        sig_in = 1'b0;
        repeat (5) @(negedge clk);
        run_window(1'b0, -1, t, v);
        checks += 1;
        if (v < 0 || a_if.freq !== 32'(model_count(t)) || a_if.freq !== 32'd0) begin
            errors++; $display("FAIL static_low got %0d (v=%0d) want 0", a_if.freq, v);
        end
        sig_in = 1'b1;
        repeat (5) @(negedge clk);
        run_window(1'b0, -1, t, v);
        checks += 1;
        if (v < 0 || a_if.freq !== 32'(model_count(t)) || a_if.freq !== 32'd0) begin
            errors++; $display("FAIL static_high got %0d (v=%0d) want 0", a_if.freq, v);
        end
        sig_in = 1'b0;
        repeat (5) @(negedge clk);
        run_window(1'b0, G - 2, t, v);
        checks += 1;
        if (v < 0 || a_if.freq !== 32'(model_count(t)) || a_if.freq !== 32'd1) begin
            errors++; $display("FAIL last_cycle_edge got %0d (v=%0d) want 1", a_if.freq, v);
        end
        sig_in = 1'b0;
        repeat (5) @(negedge clk);
        run_window(1'b0, G - 1, t, v);
        checks += 1;
        if (v < 0 || a_if.freq !== 32'(model_count(t)) || a_if.freq !== 32'd0) begin
            errors++; $display("FAIL done_edge_dropped got %0d (v=%0d) want 0", a_if.freq, v);
        end
        sig_in = 1'b0;
    endtask

    task automatic test_saturate();
        int t, v, n, exp;
        start_gen(1000);
        run_window(1'b1, -1, t, v);
        n = model_count(t);
        exp = (n > 255) ? 255 : n;
        checks += 3;
        if (v !== t + G) begin errors++; $display("FAIL sat_latency got %0d want %0d", v, t + G); end
        if (b_if.freq !== 8'(exp)) begin errors++; $display("FAIL sat_freq got %0d want %0d", b_if.freq, exp); end
        if (b_if.overflow !== (n >= 255)) begin errors++; $display("FAIL sat_ovf got %b want %b", b_if.overflow, n >= 255); end
        stop_gen();
        start_gen(5000);
        run_window(1'b1, -1, t, v);
        n = model_count(t);
        checks += 2;
        if (b_if.freq !== 8'(n) || v < 0) begin errors++; $display("FAIL unsat_freq got %0d want %0d", b_if.freq, n); end
        if (b_if.overflow !== 1'b0) begin errors++; $display("FAIL unsat_ovf got %b want 0", b_if.overflow); end
        stop_gen();
    endtask

    task automatic test_continuous();
        int t0, v, tn, exp, extra;
        start_gen(10000);
        @(negedge clk);
        a_if.cont = 1'b1;
        @(negedge clk);
        t0 = cyc - 1;
        for (int n = 0; n < 4; n++) begin
            tn = t0 + n * (G + 1);
            if (n == 3) begin
                repeat (500) @(negedge clk);
                checks += 1;
                if (a_if.busy !== 1'b1) begin errors++; $display("FAIL cont_busy got %b want 1", a_if.busy); end
                a_if.cont = 1'b0;
            end
            wait_valid_a(v);
            exp = model_count(tn);
            checks += 3;
            if (v !== tn + G) begin errors++; $display("FAIL cont_strobe%0d got %0d want %0d", n, v, tn + G); end
            if (a_if.freq !== 32'(exp)) begin errors++; $display("FAIL cont_model%0d got %0d want %0d", n, a_if.freq, exp); end
            if (a_if.freq !== 32'd50) begin errors++; $display("FAIL cont_freq%0d got %0d want 50", n, a_if.freq); end
        end
        extra = 0;
        repeat (G + 50) begin
            @(negedge clk);
            if (a_if.freq_valid) extra++;
        end
        checks += 2;
        if (extra !== 0) begin errors++; $display("FAIL cont_stop got %0d strobes want 0", extra); end
        if (a_if.busy !== 1'b0) begin errors++; $display("FAIL cont_idle_busy got %b want 0", a_if.busy); end
    endtask

    task automatic test_start_in_gate();
        int t, first, strobes;
        @(negedge clk);
        a_if.start = 1'b1;
        @(negedge clk);
        a_if.start = 1'b0;
        t = cyc - 1;
        first = -1;
        strobes = 0;
        repeat (2 * G + 50) begin
            @(negedge clk);
            if (cyc == t + 300) a_if.start = 1'b1;
            if (cyc == t + 301) a_if.start = 1'b0;
            if (a_if.freq_valid) begin
                strobes++;
                if (first < 0) first = cyc - 1;
            end
        end
        checks += 2;
        if (strobes !== 1) begin errors++; $display("FAIL ignore_start got %0d strobes want 1", strobes); end
        if (first !== t + G) begin errors++; $display("FAIL ignore_start_time got %0d want %0d", first, t + G); end
    endtask

    task automatic test_reset_mid();
        int strobes;
        @(negedge clk);
        a_if.start = 1'b1;
        @(negedge clk);
        a_if.start = 1'b0;
        repeat (498) @(negedge clk);
        checks += 1;
        if (a_if.busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got %b want 1", a_if.busy); end
        rst = 1'b1;
        #1;
        checks += 4;
        if (a_if.freq !== 32'd0) begin errors++; $display("FAIL rst_mid_freq got %0d want 0", a_if.freq); end
        if (a_if.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", a_if.busy); end
        if (a_if.freq_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", a_if.freq_valid); end
        if (a_if.overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_ovf got %b want 0", a_if.overflow); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        strobes = 0;
        repeat (G + 50) begin
            @(negedge clk);
            if (a_if.freq_valid || a_if.busy) strobes++;
        end
        checks += 1;
        if (strobes !== 0) begin errors++; $display("FAIL rst_no_report got %0d active cycles want 0", strobes); end
        stop_gen();
    endtask

    task automatic test_async();
        int t, v, exp;
        start_gen(3650);
        for (int k = 0; k < 2; k++) begin
            run_window(1'b0, -1, t, v);
            exp = model_count(t);
            checks += 3;
            if (v < 0 || a_if.freq !== 32'(exp)) begin
                errors++; $display("FAIL async_model%0d got %0d want %0d", k, a_if.freq, exp);
            end
            if (a_if.freq < 32'd136 || a_if.freq > 32'd137) begin
                errors++; $display("FAIL async_range%0d got %0d want 136..137", k, a_if.freq);
            end
            if ((^{a_if.freq, a_if.freq_valid, a_if.busy, a_if.overflow}) === 1'bx) begin
                errors++; $display("FAIL async_x%0d got X want known", k);
            end
        end
        stop_gen();
    endtask

    initial begin
        a_if.start = 1'b0;
        a_if.cont  = 1'b0;
        b_if.start = 1'b0;
        b_if.cont  = 1'b0;
        test_reset();
        test_period10();
        test_static();
        test_saturate();
        test_continuous();
        test_start_in_gate();
        test_reset_mid();
        test_async();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
